// File: rtl/rx_pkg.sv
// Shared constants and types for the lab serial link (receiver, transmitter, benches).
// Holds the default framing parameters and the receiver FSM state type.
package rx_pkg;

    localparam int          RX_WORDS        = 40;
    localparam int          RX_WORD_SIZE    = 23;
    localparam int          RX_SYNC_LEN     = 8;
    localparam logic [7:0]  RX_SYNC_PATTERN = 8'b0111_1110;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Serial line in, deserialized word/status bundle out.
// master = receiver side (drives words), slave = consumer/line-driver side.
interface serial_receiver_if #(
    parameter int WORDS     = rx_pkg::RX_WORDS,
    parameter int WORD_SIZE = rx_pkg::RX_WORD_SIZE
) ();
    localparam int CNT_W = $clog2(WORDS + 1);

    logic                 serial_in;
    logic [WORD_SIZE-2:0] word_out;
    logic                 word_valid;
    logic                 parity_err;
    logic [CNT_W-1:0]     word_count;
    logic [7:0]           err_count;
    logic                 done;

    modport master (
        input  serial_in,
        output word_out, word_valid, parity_err, word_count, err_count, done
    );

    modport slave (
        output serial_in,
        input  word_out, word_valid, parity_err, word_count, err_count, done
    );
endinterface

// File: rtl/serial_receiver_sync_detect.sv
// SYNC hunter: shifts the line into a history register while enabled.
// match is combinational on the history including the bit being sampled now; no backpressure.
module sync_detect #(
    parameter int                  SYNC_LEN     = rx_pkg::RX_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = rx_pkg::RX_SYNC_PATTERN
) (
    input  logic clk,
    input  logic rst_l,
    input  logic enable,
    input  logic serial_in,
    output logic match
);
    // Only the older SYNC_LEN-1 bits need storing; the newest comes straight off the line.
    logic [SYNC_LEN-2:0] hist_q, hist_d;
    logic [SYNC_LEN-1:0] window;

    always_comb begin
        window = {hist_q, serial_in};
        hist_d = hist_q;
        match  = 1'b0;
        if (enable) begin
            hist_d = window[SYNC_LEN-2:0];
            match  = (window == SYNC_PATTERN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) hist_q <= '0;
        else        hist_q <= hist_d;
    end
endmodule

// File: rtl/serial_receiver.sv
// Deserializer: hunts SYNC, then captures WORDS MSB-first words with odd parity in the LSB.
// word_valid pulses the cycle after the LSB edge; no backpressure, the line is never stalled.
module serial_receiver
    import rx_pkg::*;
#(
    parameter int WORDS     = RX_WORDS,
    parameter int WORD_SIZE = RX_WORD_SIZE
) (
    input  logic               clk,
    input  logic               rst_l,
    serial_receiver_if.master  rx
);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int BIT_W = $clog2(WORD_SIZE);

    rx_state_t            state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_SIZE-2:0] shreg_q, shreg_d;
    logic [WORD_SIZE-2:0] word_out_q, word_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 word_valid_q, word_valid_d;
    logic [CNT_W-1:0]     word_count_q, word_count_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [WORD_SIZE-1:0] full_word;
    logic                 sync_match;
    logic                 word_par_err;

    sync_detect #(
        .SYNC_LEN     (RX_SYNC_LEN),
        .SYNC_PATTERN (RX_SYNC_PATTERN)
    ) u_sync (
        .clk       (clk),
        .rst_l     (rst_l),
        .enable    (state_q == HUNT),
        .serial_in (rx.serial_in),
        .match     (sync_match)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        word_out_d   = word_out_q;
        parity_err_d = parity_err_q;
        word_valid_d = 1'b0;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        // The word being completed is the stored bits plus the one on the line this edge.
        full_word    = {shreg_q, rx.serial_in};
        word_par_err = ~^full_word;

        case (state_q)
            HUNT: begin
                if (sync_match) begin
                    state_d      = RECV;
                    bit_cnt_d    = BIT_W'(WORD_SIZE - 1);
                    word_count_d = '0;
                    err_count_d  = '0;
                end
            end
            RECV: begin
                shreg_d = full_word[WORD_SIZE-2:0];
                if (bit_cnt_q == '0) begin
                    word_out_d   = full_word[WORD_SIZE-1:1];
                    parity_err_d = word_par_err;
                    word_valid_d = 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    err_count_d  = sat_inc8(err_count_q, word_par_err);
                    bit_cnt_d    = BIT_W'(WORD_SIZE - 1);
                    if (word_count_q == CNT_W'(WORDS - 1)) state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= HUNT;
            bit_cnt_q    <= BIT_W'(WORD_SIZE - 1);
            shreg_q      <= '0;
            word_out_q   <= '0;
            parity_err_q <= 1'b0;
            word_valid_q <= 1'b0;
            word_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            word_out_q   <= word_out_d;
            parity_err_q <= parity_err_d;
            word_valid_q <= word_valid_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign rx.word_out   = word_out_q;
    assign rx.word_valid = word_valid_q;
    assign rx.parity_err = parity_err_q;
    assign rx.word_count = word_count_q;
    assign rx.err_count  = err_count_q;
    assign rx.done       = (state_q == DONE);
endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed bit streams, a framing model computed from the stream,
// a per-cycle compare process, and literal pins on key results.
module tb_serial_receiver;
    import rx_pkg::*;

    localparam int WS = RX_WORD_SIZE;
    localparam int NW = RX_WORDS;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    serial_receiver_if rx_if ();

    serial_receiver dut (
        .clk   (clk),
        .rst_l (rst_l),
        .rx    (rx_if)
    );

    int errors = 0;
    int checks = 0;

    bit   stim[$];
    bit   m_vld[];
    int   m_wo[];
    bit   m_pe[];
    int   m_wc[];
    int   m_ec[];
    bit   m_dn[];
    int   cur_idx = 0;
    bit   chk_en  = 1'b0;
    int   strobe_idx[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    // Appends data then a parity bit making the 23-bit total odd, optionally inverted.
    task automatic push_word(input logic [21:0] d, input bit corrupt);
        push_bits({10'd0, d}, 22);
        stim.push_back((~^d) ^ corrupt);
    endtask

    task automatic push_sync();
        push_bits({24'd0, RX_SYNC_PATTERN}, 8);
    endtask

    // Index of the first bit completing the SYNC pattern; the line is treated as zeros before the stream.
    function automatic int sync_at();
        logic [7:0] w;
        for (int i = 0; i < stim.size(); i++) begin
            w = '0;
            for (int j = 0; j < 8; j++) begin
                w = {w[6:0], ((i - 7 + j) >= 0) ? stim[i - 7 + j] : 1'b0};
            end
            if (w == RX_SYNC_PATTERN) return i;
        end
        return -1;
    endfunction

    // Word k occupies stream bits s+1+WS*k .. s+WS*(k+1); its strobe follows the last of those.
    task automatic build_model();
        int len, s, k, wo, wc, ec;
        bit pe, dn;
        logic [WS-1:0] word;
        len = stim.size();
        m_vld = new[len]; m_wo = new[len]; m_pe = new[len];
        m_wc  = new[len]; m_ec = new[len]; m_dn = new[len];
        s = sync_at();
        wo = 0; wc = 0; ec = 0; pe = 1'b0; dn = 1'b0;
        for (int i = 0; i < len; i++) begin
            m_vld[i] = 1'b0;
            if (s >= 0 && i > s && ((i - s) % WS) == 0 && ((i - s) / WS) <= NW) begin
                k = (i - s) / WS;
                for (int j = 0; j < WS; j++) word[WS - 1 - j] = stim[i - WS + 1 + j];
                wo = int'(word[WS-1:1]);
                pe = ~^word;
                wc = k;
                ec = (ec + int'(pe) > 255) ? 255 : ec + int'(pe);
                dn = (k == NW);
                m_vld[i] = 1'b1;
            end
            m_wo[i] = wo; m_pe[i] = pe; m_wc[i] = wc; m_ec[i] = ec; m_dn[i] = dn;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_l) begin
            chk("rst_word_valid", int'(rx_if.word_valid), 0);
            chk("rst_word_out",   int'(rx_if.word_out),   0);
            chk("rst_parity_err", int'(rx_if.parity_err), 0);
            chk("rst_word_count", int'(rx_if.word_count), 0);
            chk("rst_err_count",  int'(rx_if.err_count),  0);
            chk("rst_done",       int'(rx_if.done),       0);
        end else if (chk_en) begin
            chk("word_valid", int'(rx_if.word_valid), int'(m_vld[cur_idx]));
            if (rx_if.word_valid) strobe_idx.push_back(cur_idx);
            chk("word_out",   int'(rx_if.word_out),   m_wo[cur_idx]);
            chk("parity_err", int'(rx_if.parity_err), int'(m_pe[cur_idx]));
            chk("word_count", int'(rx_if.word_count), m_wc[cur_idx]);
            chk("err_count",  int'(rx_if.err_count),  m_ec[cur_idx]);
            chk("done",       int'(rx_if.done),       int'(m_dn[cur_idx]));
        end
    end

    // Holds reset for nrst edges, then plays stim one bit per edge with the model checking each edge.
    task automatic run_stream(input int nrst);
        chk_en = 1'b0;
        rx_if.serial_in = 1'b0;
        rst_l = 1'b0;
        repeat (nrst) begin
            @(posedge clk);
            #2;
        end
        rst_l = 1'b1;
        build_model();
        strobe_idx.delete();
        chk_en = 1'b1;
        for (int i = 0; i < stim.size(); i++) begin
            rx_if.serial_in = stim[i];
            cur_idx = i;
            @(posedge clk);
            #2;
        end
        chk_en = 1'b0;
        rx_if.serial_in = 1'b0;
    endtask

    initial begin
        logic [21:0] d;
        rx_if.serial_in = 1'b0;

        // Reset then 50 idle cycles.
        stim.delete();
        push_bits(32'd0, 25); push_bits(32'd0, 25);
        run_stream(3);
        chk("idle_strobes", strobe_idx.size(), 0);
        chk("idle_done", int'(rx_if.done), 0);

        // One good word right after SYNC.
        stim.delete();
        push_sync(); push_word(22'h2A5A5A, 1'b0);
        run_stream(2);
        chk("t2_strobes", strobe_idx.size(), 1);
        if (strobe_idx.size() > 0) chk("t2_strobe_at", strobe_idx[0], 30);
        chk("t2_word_out", int'(rx_if.word_out), 32'h2A5A5A);
        chk("t2_parity_err", int'(rx_if.parity_err), 0);
        chk("t2_word_count", int'(rx_if.word_count), 1);

        // Bad-parity word (even total), then a good word.
        stim.delete();
        push_sync(); push_word(22'h000001, 1'b1); push_word(22'h2A5A5A, 1'b0);
        run_stream(2);
        chk("t3_model_pe", int'(m_pe[30]), 1);
        chk("t3_model_ec", m_ec[30], 1);
        chk("t3_strobes", strobe_idx.size(), 2);
        chk("t3_parity_err", int'(rx_if.parity_err), 0);
        chk("t3_err_count", int'(rx_if.err_count), 1);

        // Near-miss pattern, then the real SYNC.
        stim.delete();
        push_bits(32'h7C, 8); push_sync(); push_word(22'h155555, 1'b0);
        run_stream(2);
        chk("t4_model_sync", sync_at(), 15);
        chk("t4_strobes", strobe_idx.size(), 1);
        if (strobe_idx.size() > 0) chk("t4_strobe_at", strobe_idx[0], 38);
        chk("t4_word_out", int'(rx_if.word_out), 32'h155555);

        // Partial word aborted by reset, then a fresh message.
        stim.delete();
        push_sync(); push_bits(32'h2AB, 10);
        run_stream(2);
        chk("t5a_strobes", strobe_idx.size(), 0);
        stim.delete();
        push_sync(); push_word(22'h0ABCDE, 1'b0);
        run_stream(1);
        chk("t5_strobes", strobe_idx.size(), 1);
        if (strobe_idx.size() > 0) chk("t5_strobe_at", strobe_idx[0], 30);
        chk("t5_word_out", int'(rx_if.word_out), 32'h0ABCDE);
        chk("t5_word_count", int'(rx_if.word_count), 1);

        // Full message with SYNC inside data, some bad words, then trailing bits.
        stim.delete();
        push_sync();
        for (int k = 0; k < NW; k++) begin
            d = 22'(k * 32'h1357B) ^ 22'h000FC0;
            if (k == 5) d = 22'h07E07E;
            push_word(d, (k % 7) == 3);
        end
        push_sync(); push_bits(32'h3FFFFF, 22);
        run_stream(2);
        chk("t6_strobes", strobe_idx.size(), 40);
        for (int k = 1; k < strobe_idx.size(); k++) chk("t6_gap", strobe_idx[k] - strobe_idx[k-1], 23);
        if (strobe_idx.size() == 40) chk("t6_last_at", strobe_idx[39], 927);
        chk("t6_done", int'(rx_if.done), 1);
        chk("t6_word_count", int'(rx_if.word_count), 40);
        chk("t6_err_count", int'(rx_if.err_count), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
